// File: rtl/float2fix.sv
`default_nettype none
// ============================================================================
//  Module   : float2fix
//  Purpose  : Two-stage pipelined IEEE-754 single-precision to signed
//             fixed-point converter. The number of fraction bits is set per
//             sample. Right shifts round half away from zero, out-of-range
//             values saturate, and NaN, zero and denormal inputs give 0.
//  Revision : 1.0  initial release
// ============================================================================
module float2fix (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] fraction_len,
  input  logic        src_valid,
  input  logic [31:0] src,
  output logic        dst_valid,
  output logic [31:0] dst
);

  localparam logic [1:0]  CLS_ZERO = 2'd0;  // zero or denormal (flushed)
  localparam logic [1:0]  CLS_NORM = 2'd1;
  localparam logic [1:0]  CLS_INF  = 2'd2;
  localparam logic [1:0]  CLS_NAN  = 2'd3;
  localparam logic [31:0] POS_SAT  = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_SAT  = 32'h8000_0000;

  // ---------------- stage 1: decode ----------------
  logic [7:0]        exp_w;
  logic [4:0]        flen_w;
  logic [1:0]        s1_class_d;
  logic [23:0]       s1_mant_d;
  logic signed [9:0] s1_shift_d;

  logic              s1_valid_q;
  logic              s1_sign_q;
  logic [1:0]        s1_class_q;
  logic [23:0]       s1_mant_q;
  logic signed [9:0] s1_shift_q;

  assign exp_w  = src[30:23];
  // Any fraction length above 31 behaves as 31.
  assign flen_w = (|fraction_len[31:5]) ? 5'd31 : fraction_len[4:0];

  // Classify the input and form the mantissa and the signed scaling shift.
  always_comb begin
    s1_mant_d  = {1'b1, src[22:0]};
    s1_shift_d = $signed({2'b00, exp_w}) - 10'sd150 + $signed({5'b00000, flen_w});
    s1_class_d = CLS_NORM;
    if (exp_w == 8'd0) begin
      s1_class_d = CLS_ZERO;
    end else if (exp_w == 8'hFF) begin
      s1_class_d = (src[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
    end
  end

  // Stage 1 register: captures a sample only when the pipeline advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_class_q <= CLS_ZERO;
      s1_mant_q  <= 24'd0;
      s1_shift_q <= 10'sd0;
    end else if (enable) begin
      s1_valid_q <= src_valid;
      if (src_valid) begin
        s1_sign_q  <= src[31];
        s1_class_q <= s1_class_d;
        s1_mant_q  <= s1_mant_d;
        s1_shift_q <= s1_shift_d;
      end
    end
  end

  // ---------------- stage 2: shift, round, saturate, sign ----------------
  logic [32:0] mag;
  logic [24:0] mant_ext;
  logic [4:0]  rsh;
  logic        sat;
  logic [31:0] dst_d;
  logic        dst_valid_q;
  logic [31:0] dst_q;

  // The mantissa gets a zero on top so the rounding bit for a 25-bit right
  // shift can be read without going out of range.
  assign mant_ext = {1'b0, s1_mant_q};

  // Scale the mantissa by the signed shift, then clamp to the 32-bit range.
  always_comb begin
    mag   = 33'd0;
    rsh   = 5'd0;
    sat   = 1'b0;
    dst_d = 32'd0;
    if (s1_shift_q >= 10'sd8) begin
      // A normal mantissa moved up by 8 or more is already at least 2^31.
      sat = 1'b1;
    end else if (s1_shift_q >= 10'sd0) begin
      mag = {9'd0, s1_mant_q} << s1_shift_q[2:0];
    end else if (s1_shift_q >= -10'sd25) begin
      rsh = 5'(-s1_shift_q);
      mag = {8'd0, (mant_ext >> rsh)} + {32'd0, mant_ext[rsh - 5'd1]};
    end
    if (mag[32:31] != 2'b00) begin
      sat = 1'b1;
    end

    case (s1_class_q)
      CLS_NORM: begin
        if (sat) begin
          dst_d = s1_sign_q ? NEG_SAT : POS_SAT;
        end else begin
          // Negating a zero magnitude gives 0, so a result of -0 cannot occur.
          dst_d = s1_sign_q ? (32'd0 - mag[31:0]) : mag[31:0];
        end
      end
      CLS_INF:  dst_d = s1_sign_q ? NEG_SAT : POS_SAT;
      default:  dst_d = 32'd0;
    endcase
  end

  // Output register: dst keeps its value through bubbles and stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_valid_q <= 1'b0;
      dst_q       <= 32'd0;
    end else if (enable) begin
      dst_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        dst_q <= dst_d;
      end
    end
  end

  assign dst_valid = dst_valid_q;
  assign dst       = dst_q;

endmodule
`default_nettype wire

// File: tb/tb_float2fix.sv
`default_nettype none
// ============================================================================
//  Module   : tb_float2fix
//  Purpose  : Self-checking bench for float2fix. It runs directed steps and
//             then random traffic. Each result is compared with an arithmetic
//             reference model and a two-deep pipeline model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_float2fix;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] fraction_len;
  logic        src_valid;
  logic [31:0] src;
  logic        dst_valid;
  logic [31:0] dst;

  int compared   = 0;
  int mismatched = 0;

  // Reference pipeline: expected stage-1 content and expected outputs.
  bit          m1_v;
  logic [31:0] m1_d;
  bit          m2_v;
  logic [31:0] m2_d;

  float2fix dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .fraction_len (fraction_len),
    .src_valid    (src_valid),
    .src          (src),
    .dst_valid    (dst_valid),
    .dst          (dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact value = mant * 2^(exp-150+flen). Rounding is half away from zero:
  // add half an output LSB to the magnitude, then divide.
  function automatic logic [31:0] ref_conv(input logic [31:0] f, input logic [31:0] flen_in);
    int     flen;
    int     e;
    int     s;
    longint m;
    longint mag;
    bit     neg;
    flen = (flen_in > 32'd31) ? 31 : int'(flen_in);
    e    = int'(f[30:23]);
    neg  = f[31];
    m    = longint'({1'b1, f[22:0]});
    if (e == 0) return 32'h0000_0000;
    if (e == 255) begin
      if (f[22:0] != 23'd0) return 32'h0000_0000;
      return neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    s = e - 150 + flen;
    if (s > 30)        mag = longint'(1) << 40;
    else if (s >= 0)   mag = m << s;
    else if (-s >= 40) mag = 0;
    else               mag = (m + (longint'(1) << (-s - 1))) >> (-s);
    if (mag >= (longint'(1) << 31)) return neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (neg) return 32'(-mag);
    return 32'(mag);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Apply one set of inputs over one clock edge, advance the model,
  // then compare both outputs just after the edge.
  task automatic step(input bit en, input bit v, input logic [31:0] fl,
                      input logic [31:0] s, input string tag);
    enable       = en;
    src_valid    = v;
    fraction_len = fl;
    src          = s;
    @(posedge clk);
    if (en) begin
      m2_v = m1_v;
      if (m1_v) m2_d = m1_d;
      m1_v = v;
      m1_d = ref_conv(s, fl);
    end
    #1;
    check({tag, "_valid"}, {31'd0, dst_valid}, {31'd0, m2_v});
    check({tag, "_dst"}, dst, m2_d);
  endtask

  // Literal check of the result currently on the output.
  task automatic expect_out(input string tag, input logic [31:0] val);
    check({tag, "_lit_valid"}, {31'd0, dst_valid}, 32'd1);
    check({tag, "_lit_dst"}, dst, val);
  endtask

  task automatic bubble(input string tag);
    step(1'b1, 1'b0, 32'd0, 32'd0, tag);
  endtask

  initial begin
    bit          en;
    bit          v;
    logic [31:0] fl;
    logic [31:0] s;

    rst = 1'b1; enable = 1'b0; src_valid = 1'b0; fraction_len = 32'd0; src = 32'd0;
    m1_v = 1'b0; m1_d = 32'd0; m2_v = 1'b0; m2_d = 32'd0;

    // Reset state
    @(posedge clk); #1;
    check("reset_valid", {31'd0, dst_valid}, 32'd0);
    check("reset_dst", dst, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic conversion: 1.5 with 8 fraction bits, two cycles of latency
    step(1'b1, 1'b1, 32'd8, 32'h3FC0_0000, "basic_acc");
    bubble("basic_w1");
    expect_out("basic", 32'h0000_0180);
    bubble("basic_w2");

    // Rounding and special values, streamed back to back
    step(1'b1, 1'b1, 32'd0, 32'hC020_0000, "rnd_m25");
    step(1'b1, 1'b1, 32'd0, 32'h3EFF_FFFF, "rnd_049");
    expect_out("rnd_m25", 32'hFFFF_FFFD);
    step(1'b1, 1'b1, 32'd0, 32'h4F80_0000, "sat_2p32");
    expect_out("rnd_049", 32'h0000_0000);
    step(1'b1, 1'b1, 32'd5, 32'hFF80_0000, "neg_inf");
    expect_out("sat_2p32", 32'h7FFF_FFFF);
    step(1'b1, 1'b1, 32'd5, 32'h7FC0_0000, "nan");
    expect_out("neg_inf", 32'h8000_0000);
    step(1'b1, 1'b1, 32'd5, 32'h0000_0001, "denorm");
    expect_out("nan", 32'h0000_0000);
    step(1'b1, 1'b1, 32'd40, 32'h3F80_0000, "flen_clamp");
    expect_out("denorm", 32'h0000_0000);
    step(1'b1, 1'b1, 32'd0, 32'hCF00_0000, "neg_2p31");
    expect_out("flen_clamp", 32'h7FFF_FFFF);
    step(1'b1, 1'b1, 32'd0, 32'hBE80_0000, "neg_quarter");
    expect_out("neg_2p31", 32'h8000_0000);
    step(1'b1, 1'b1, 32'd0, 32'hBF00_0000, "neg_half");
    expect_out("neg_quarter", 32'h0000_0000);
    step(1'b1, 1'b1, 32'd0, 32'h8000_0000, "neg_zero");
    expect_out("neg_half", 32'hFFFF_FFFF);
    bubble("spec_w1");
    expect_out("neg_zero", 32'h0000_0000);
    bubble("spec_w2");
    bubble("spec_w3");

    // Stall in the middle of a back-to-back stream
    step(1'b1, 1'b1, 32'd4, 32'h3F80_0000, "stall_one");
    step(1'b1, 1'b1, 32'd4, 32'h4000_0000, "stall_two");
    expect_out("stall_pre", 32'h0000_0010);
    step(1'b0, 1'b1, 32'd4, 32'h4040_0000, "stall_c1");
    expect_out("stall_hold1", 32'h0000_0010);
    step(1'b0, 1'b1, 32'd4, 32'h4040_0000, "stall_c2");
    step(1'b0, 1'b1, 32'd4, 32'h4040_0000, "stall_c3");
    expect_out("stall_hold3", 32'h0000_0010);
    step(1'b1, 1'b1, 32'd4, 32'h4040_0000, "stall_three");
    expect_out("stall_out2", 32'h0000_0020);
    bubble("stall_w1");
    expect_out("stall_out3", 32'h0000_0030);
    bubble("stall_w2");
    check("stall_nodup_valid", {31'd0, dst_valid}, 32'd0);

    // Asynchronous reset with two samples in flight
    step(1'b1, 1'b1, 32'd4, 32'h40A0_0000, "rst_a");
    step(1'b1, 1'b1, 32'd4, 32'h40C0_0000, "rst_b");
    step(1'b1, 1'b1, 32'd4, 32'h40E0_0000, "rst_c");
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", {31'd0, dst_valid}, 32'd0);
    check("rst_async_dst", dst, 32'd0);
    m1_v = 1'b0; m1_d = 32'd0; m2_v = 1'b0; m2_d = 32'd0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    bubble("post_rst_1");
    bubble("post_rst_2");
    bubble("post_rst_3");
    step(1'b1, 1'b1, 32'd2, 32'h4110_0000, "post_rst_acc");
    bubble("post_rst_w1");
    expect_out("post_rst", 32'h0000_0024);

    // Random traffic compared with the reference model
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 4) != 0);
      v  = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 40));
      case ($urandom_range(0, 15))
        0:       s = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(0, 1) * $urandom)};
        1:       s = {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom)};
        2, 3:    s = $urandom;
        default: s = {$urandom_range(0, 1) == 1, 8'($urandom_range(90, 170)), 23'($urandom)};
      endcase
      step(en, v, fl, s, "rand");
    end
    bubble("drain_1");
    bubble("drain_2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
